// File: rtl/tt_um_seq_divider_8x4.sv
// Restoring divider for an 8-bit dividend and a 4-bit divisor, one quotient bit per clock.
// state | meaning
// IDLE  | reset, no result computed yet
// RUN   | eight shift/subtract iterations in progress
// DONE  | result valid, waiting for the next start event
module tt_um_seq_divider_8x4 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [7:0]   r_dvd;
  logic [3:0]   r_dvs;
  logic [3:0]   r_p;
  logic [2:0]   r_count;
  logic [7:0]   r_quot;
  logic [3:0]   r_rem;
  logic         r_start_q;

  logic         w_start_evt;
  logic         w_dvs_zero;
  logic         w_load;
  logic         w_last;
  logic [4:0]   w_p_shift;
  logic [4:0]   w_p_next;
  logic         w_ge;
  logic         w_busy;
  logic         w_done;
  logic         w_unused;

  assign w_unused    = &{1'b0, uio_in[7:6]};
  assign w_start_evt = uio_in[4] & ~r_start_q;
  assign w_dvs_zero  = (uio_in[3:0] == 4'd0);
  assign w_load      = w_start_evt & (r_state != RUN);
  assign w_last      = (r_count == 3'd7);

  // After a subtraction P < divisor, so only P[3:0] needs to be stored between iterations.
  assign w_p_shift = {r_p, r_dvd[7]};
  assign w_ge      = (w_p_shift >= {1'b0, r_dvs});
  assign w_p_next  = w_ge ? (w_p_shift - {1'b0, r_dvs}) : w_p_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_start_evt) begin
          w_state_nxt = w_dvs_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state == RUN);
    w_done  = (r_state == DONE);
    uio_out = {w_done, w_busy, 6'b0};
    uio_oe  = 8'b1100_0000;
    uo_out  = uio_in[5] ? {4'b0, r_rem} : r_quot;
  end

  // Quotient bits shift into the vacated LSBs of the dividend register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd     <= 8'd0;
      r_dvs     <= 4'd0;
      r_p       <= 4'd0;
      r_count   <= 3'd0;
      r_quot    <= 8'd0;
      r_rem     <= 4'd0;
      r_start_q <= 1'b0;
    end else if (ena) begin
      r_start_q <= uio_in[4];
      if (w_load) begin
        if (w_dvs_zero) begin
          r_quot <= 8'hFF;
          r_rem  <= 4'hF;
        end else begin
          r_dvd   <= ui_in;
          r_dvs   <= uio_in[3:0];
          r_p     <= 4'd0;
          r_count <= 3'd0;
        end
      end else if (r_state == RUN) begin
        r_p     <= w_p_next[3:0];
        r_dvd   <= {r_dvd[6:0], w_ge};
        r_count <= r_count + 3'd1;
        if (w_last) begin
          r_quot <= {r_dvd[6:0], w_ge};
          r_rem  <= w_p_next[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_seq_divider_8x4.sv
// Self-checking bench for tt_um_seq_divider_8x4: vector table plus hand-written start/ena/reset sequences.
module tb_tt_um_seq_divider_8x4;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  tt_um_seq_divider_8x4 dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  vec_t        vecs[10];
  logic [11:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  wire busy = uio_out[6];
  wire done = uio_out[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done is seen, bounded; busy and done must never overlap.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
      tick();
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_result(input string nm);
    logic [11:0] exp;
    if (sb_q.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      uio_in[5] = 1'b0;
      #1;
      check({nm, "_quot"}, {24'b0, uo_out}, {24'b0, exp[11:4]});
      uio_in[5] = 1'b1;
      #1;
      check({nm, "_rem"}, {24'b0, uo_out}, {28'b0, exp[3:0]});
      uio_in[5] = 1'b0;
    end
  endtask

  task automatic start_op(input logic [7:0] dvd, input logic [3:0] dvs);
    ui_in  = dvd;
    uio_in = {3'b000, 1'b1, dvs};
    tick();
    uio_in[4] = 1'b0;
  endtask

  initial begin
    int n;
    int total;
    vecs[0] = '{8'd225, 4'd15, 8'd15,  4'd0};
    vecs[1] = '{8'd200, 4'd7,  8'd28,  4'd4};
    vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0};
    vecs[3] = '{8'd9,   4'd0,  8'hFF,  4'hF};
    vecs[4] = '{8'd0,   4'd5,  8'd0,   4'd0};
    vecs[5] = '{8'd255, 4'd15, 8'd17,  4'd0};
    vecs[6] = '{8'd254, 4'd13, 8'd19,  4'd7};
    vecs[7] = '{8'd7,   4'd9,  8'd0,   4'd7};
    vecs[8] = '{8'd128, 4'd11, 8'd11,  4'd7};
    vecs[9] = '{8'd100, 4'd3,  8'd33,  4'd1};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quot", {24'b0, uo_out}, 32'd0);
    uio_in[5] = 1'b1;
    #1;
    check("rst_rem", {24'b0, uo_out}, 32'd0);
    uio_in[5] = 1'b0;
    check("uio_oe", {24'b0, uio_oe}, 32'hC0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      sb_q.push_back({vecs[i].q, vecs[i].r});
      start_op(vecs[i].dvd, vecs[i].dvs);
      if (vecs[i].dvs != 4'd0) begin
        check("vec_busy_after_start", {31'b0, busy}, 32'd1);
        check("vec_done_after_start", {31'b0, done}, 32'd0);
      end
      wait_done(n);
      check("vec_latency", n, (vecs[i].dvs == 4'd0) ? 32'd0 : 32'd8);
      compare_result("vec");
      tick();
      check("vec_done_holds", {31'b0, done}, 32'd1);
    end

    // Second start while running must be ignored.
    sb_q.push_back({8'd33, 4'd1});
    start_op(8'd100, 4'd3);
    tick();
    tick();
    ui_in  = 8'd50;
    uio_in = {3'b000, 1'b1, 4'd5};
    tick();
    uio_in[4] = 1'b0;
    wait_done(n);
    check("ignored_start_latency", n + 3, 32'd8);
    compare_result("ignored_start");

    // Start held high: exactly one operation, no retrigger on completion.
    tick();
    sb_q.push_back({8'd5, 4'd0});
    ui_in  = 8'd20;
    uio_in = {3'b000, 1'b1, 4'd4};
    tick();
    for (int i = 0; i < 19; i++) begin
      check("held_busy_done_exclusive", {31'b0, busy & done}, 32'd0);
      tick();
    end
    check("held_done", {31'b0, done}, 32'd1);
    check("held_busy", {31'b0, busy}, 32'd0);
    compare_result("held");
    uio_in[4] = 1'b0;
    tick();
    sb_q.push_back({8'd12, 4'd5});
    start_op(8'd77, 4'd6);
    check("restart_busy", {31'b0, busy}, 32'd1);
    check("restart_old_quot", {24'b0, uo_out}, 32'd5);
    wait_done(n);
    check("restart_latency", n, 32'd8);
    compare_result("restart");

    // ena low for 3 cycles mid-run delays done by 3 cycles.
    tick();
    sb_q.push_back({8'd28, 4'd4});
    start_op(8'd200, 4'd7);
    tick();
    tick();
    tick();
    ena = 1'b0;
    tick();
    tick();
    tick();
    check("ena_freeze_busy", {31'b0, busy}, 32'd1);
    ena = 1'b1;
    wait_done(n);
    total = n + 6;
    check("ena_latency", total, 32'd11);
    compare_result("ena");

    // Reset mid-run clears everything immediately.
    tick();
    start_op(8'd225, 4'd15);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quot", {24'b0, uo_out}, 32'd0);
    uio_in[5] = 1'b1;
    #1;
    check("midrst_rem", {24'b0, uo_out}, 32'd0);
    uio_in[5] = 1'b0;
    rst_n = 1'b1;
    tick();
    check("postrst_idle", {30'b0, done, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
